// File: rtl/pipe_stage_reg_pkg.sv
// pipe_stage_reg_pkg: shared payload layouts, widths and NOP encodings for the back-end stage registers
package pipe_stage_reg_pkg;
    localparam int PIPE_DATA_W = 128;
    localparam logic [2:0] ALU_SEL_NOP = 3'b000;
    localparam logic [7:0] ALU_NOP = 8'h00;
    typedef struct packed {
        logic [2:0]  alusel;
        logic [7:0]  aluop;
        logic [31:0] reg1;
        logic [31:0] reg2;
        logic [4:0]  waddr;
        logic        wen;
    } id_ex_t;
    typedef struct packed {
        logic [7:0]  aluop;
        logic [31:0] mem_addr;
        logic [31:0] wdata;
        logic [4:0]  waddr;
        logic        wen;
    } ex_mem_t;
    typedef struct packed {
        logic [31:0] wdata;
        logic [4:0]  waddr;
        logic        wen;
    } mem_wb_t;
    localparam int ID_EX_W = $bits(id_ex_t);
    localparam int EX_MEM_W = $bits(ex_mem_t);
    localparam int MEM_WB_W = $bits(mem_wb_t);
    localparam id_ex_t ID_EX_NOP = '{alusel: ALU_SEL_NOP, aluop: ALU_NOP, default: '0};
    localparam ex_mem_t EX_MEM_NOP = '{aluop: ALU_NOP, default: '0};
    localparam mem_wb_t MEM_WB_NOP = '0;
endpackage

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic valid/ready pipeline register with flush, NOP bubbles and optional skid entry
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int                DATA_W  = PIPE_DATA_W,
    parameter logic [DATA_W-1:0] NOP_VAL = '0,
    parameter bit                SKID_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);
    logic              m_valid, s_valid, m_valid_n, s_valid_n;
    logic [DATA_W-1:0] m_data, s_data, m_data_n, s_data_n;
    logic              accept, consume;
    assign accept    = in_valid & in_ready;
    assign consume   = m_valid & out_ready;
    assign out_valid = m_valid;
    assign out_data  = m_valid ? m_data : NOP_VAL;
    // Main entry refills from skid first to keep FIFO order; skid only fills when main is stalled
    always_comb begin
        m_valid_n = m_valid;
        m_data_n  = m_data;
        s_valid_n = s_valid;
        s_data_n  = s_data;
        if (flush) begin
            m_valid_n = 1'b0;
            m_data_n  = NOP_VAL;
            s_valid_n = 1'b0;
            s_data_n  = NOP_VAL;
        end else if (!m_valid || consume) begin
            m_valid_n = s_valid | accept;
            m_data_n  = s_valid ? s_data : (accept ? in_data : NOP_VAL);
            s_valid_n = 1'b0;
            s_data_n  = NOP_VAL;
        end else if (accept) begin
            s_valid_n = 1'b1;
            s_data_n  = in_data;
        end
    end
    // Entry registers and registered occupancy count
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid   <= 1'b0;
            m_data    <= NOP_VAL;
            s_valid   <= 1'b0;
            s_data    <= NOP_VAL;
            occupancy <= 2'd0;
        end else begin
            m_valid   <= m_valid_n;
            m_data    <= m_data_n;
            s_valid   <= s_valid_n;
            s_data    <= s_data_n;
            occupancy <= {1'b0, m_valid_n} + {1'b0, s_valid_n};
        end
    end
    generate
        if (SKID_EN) begin : g_skid
            logic ready_q;
            // Ready comes from a flop so out_ready never reaches in_ready combinationally
            always_ff @(posedge clk) begin
                ready_q <= rst ? 1'b1 : ~s_valid_n;
            end
            assign in_ready = ready_q;
        end else begin : g_direct
            assign in_ready = ~m_valid | out_ready;
        end
    endgenerate
    // Invariants: skid is never occupied behind an empty main entry; single-entry mode never holds two
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (m_valid || !s_valid);
            assert (SKID_EN || occupancy <= 2'd1);
        end
    end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed table plus randomized checks of both skid variants against a FIFO model
module tb_pipe_stage_reg;
    localparam int W = 16;
    localparam logic [W-1:0] NOP = 16'hBEEF;
    logic clk = 1'b0;
    logic rst, flush, in_valid, out_ready;
    logic [W-1:0] in_data;
    logic s_ir, s_ov, n_ir, n_ov;
    logic [W-1:0] s_od, n_od;
    logic [1:0] s_occ, n_occ;
    int checks = 0;
    int errors = 0;
    bit known = 1'b0;
    logic [W-1:0] qs[$];
    logic [W-1:0] qn[$];

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(W), .NOP_VAL(NOP), .SKID_EN(1'b1)) u_skid (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(s_ir),
        .in_data(in_data), .out_valid(s_ov), .out_ready(out_ready), .out_data(s_od),
        .occupancy(s_occ)
    );
    pipe_stage_reg #(.DATA_W(W), .NOP_VAL(NOP), .SKID_EN(1'b0)) u_noskid (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(n_ir),
        .in_data(in_data), .out_valid(n_ov), .out_ready(out_ready), .out_data(n_od),
        .occupancy(n_occ)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each stage is a FIFO of capacity 2 (skid) or 1 (no skid); head is presented, else NOP
    task automatic tick();
        bit s_rdy, n_rdy;
        #1;
        s_rdy = qs.size() < 2;
        n_rdy = qn.size() == 0 || out_ready;
        if (known) begin
            chk("skid_valid", 32'(s_ov), 32'(qs.size() != 0));
            chk("skid_data", 32'(s_od), 32'(qs.size() != 0 ? qs[0] : NOP));
            chk("skid_occ", 32'(s_occ), 32'(qs.size()));
            chk("skid_ready", 32'(s_ir), 32'(s_rdy));
            chk("noskid_valid", 32'(n_ov), 32'(qn.size() != 0));
            chk("noskid_data", 32'(n_od), 32'(qn.size() != 0 ? qn[0] : NOP));
            chk("noskid_occ", 32'(n_occ), 32'(qn.size()));
            chk("noskid_ready", 32'(n_ir), 32'(n_rdy));
        end
        @(posedge clk);
        if (rst || flush) begin
            qs.delete();
            qn.delete();
            if (rst) known = 1'b1;
        end else begin
            if (qs.size() != 0 && out_ready) void'(qs.pop_front());
            if (in_valid && s_rdy) qs.push_back(in_data);
            if (qn.size() != 0 && out_ready) void'(qn.pop_front());
            if (in_valid && n_rdy) qn.push_back(in_data);
        end
        #1;
    endtask

    typedef struct {
        bit rst, flush, iv;
        logic [W-1:0] d;
        bit ordy, check, ev;
        logic [W-1:0] ed;
        logic [1:0] eocc;
        bit erdy;
    } vec_t;
    vec_t tbl[19];

    initial begin
        //              rst flush iv  data   ordy chk ev  exp_data occ rdy
        tbl[0]  = '{1, 0, 1, 16'hAB, 0, 0, 0, NOP,    2'd0, 1};
        tbl[1]  = '{1, 0, 1, 16'hAB, 0, 1, 0, NOP,    2'd0, 1};
        tbl[2]  = '{0, 0, 1, 16'h11, 0, 1, 0, NOP,    2'd0, 1};
        tbl[3]  = '{0, 0, 1, 16'h22, 0, 1, 1, 16'h11, 2'd1, 1};
        tbl[4]  = '{0, 0, 1, 16'h33, 0, 1, 1, 16'h11, 2'd2, 0};
        tbl[5]  = '{0, 0, 1, 16'h33, 0, 1, 1, 16'h11, 2'd2, 0};
        tbl[6]  = '{0, 0, 1, 16'h33, 1, 1, 1, 16'h11, 2'd2, 0};
        tbl[7]  = '{0, 0, 1, 16'h33, 1, 1, 1, 16'h22, 2'd1, 1};
        tbl[8]  = '{0, 0, 0, 16'h00, 1, 1, 1, 16'h33, 2'd1, 1};
        tbl[9]  = '{0, 0, 0, 16'h00, 0, 1, 0, NOP,    2'd0, 1};
        tbl[10] = '{0, 0, 1, 16'h44, 0, 1, 0, NOP,    2'd0, 1};
        tbl[11] = '{0, 0, 1, 16'h55, 0, 1, 1, 16'h44, 2'd1, 1};
        tbl[12] = '{0, 1, 1, 16'h66, 0, 1, 1, 16'h44, 2'd2, 0};
        tbl[13] = '{0, 0, 0, 16'h00, 1, 1, 0, NOP,    2'd0, 1};
        tbl[14] = '{0, 1, 1, 16'h77, 1, 1, 0, NOP,    2'd0, 1};
        tbl[15] = '{0, 0, 0, 16'h00, 1, 1, 0, NOP,    2'd0, 1};
        tbl[16] = '{0, 0, 1, 16'h88, 0, 1, 0, NOP,    2'd0, 1};
        tbl[17] = '{0, 1, 0, 16'h00, 1, 1, 1, 16'h88, 2'd1, 1};
        tbl[18] = '{0, 0, 0, 16'h00, 1, 1, 0, NOP,    2'd0, 1};
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        for (int i = 0; i < 19; i++) begin
            rst = tbl[i].rst; flush = tbl[i].flush; in_valid = tbl[i].iv;
            in_data = tbl[i].d; out_ready = tbl[i].ordy;
            #1;
            if (tbl[i].check) begin
                chk($sformatf("tbl%0d_valid", i), 32'(s_ov), 32'(tbl[i].ev));
                chk($sformatf("tbl%0d_data", i), 32'(s_od), 32'(tbl[i].ed));
                chk($sformatf("tbl%0d_occ", i), 32'(s_occ), 32'(tbl[i].eocc));
                chk($sformatf("tbl%0d_ready", i), 32'(s_ir), 32'(tbl[i].erdy));
            end
            tick();
        end
        rst = 1'b0; flush = 1'b0; out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            in_valid = 1'b1; in_data = W'(i);
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1;
            out_ready = (i % 2) == 0;
            if (i == 0 || s_ir || n_ir) in_data = W'($urandom);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        for (int i = 0; i < 10000; i++) begin
            rst = ($urandom % 700) == 0;
            flush = ($urandom % 20) == 0;
            in_valid = ($urandom % 4) != 0;
            in_data = W'($urandom);
            out_ready = ($urandom % 3) != 0;
            tick();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
